// File: rtl/serial_add_sequencer_if.sv
// Handshake and operand/result bus of the bit-serial add/subtract sequencer.
// The control FSM drives the master side; the sequencer owns the slave side.
interface serial_add_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             overflow;
  logic             zero;

  modport master (
    output start, op_sub, a_in, b_in,
    input  busy, done, result, c_out, overflow, zero
  );

  modport slave (
    input  start, op_sub, a_in, b_in,
    output busy, done, result, c_out, overflow, zero
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// Bit-serial add/subtract through a single gate-level full adder, LSB first.
// Define SERIAL_ADD_SUB_EN to honour op_sub; otherwise the unit is add-only.
module full_adder (
  input  wire a,
  input  wire b,
  input  wire cin,
  output wire sum,
  output wire cout
);
  wire ab_x;
  wire ab_a;
  wire c_a;

  xor g_x1 (ab_x, a, b);
  xor g_x2 (sum, ab_x, cin);
  and g_a1 (ab_a, a, b);
  and g_a2 (c_a, ab_x, cin);
  or  g_o1 (cout, ab_a, c_a);
endmodule

module serial_add_sequencer #(
  parameter int WIDTH = 32
) (
  input logic                  clock,
  input logic                  reset,
  serial_add_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MSB_M1   = CW'(WIDTH - 2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] b_load;
  logic [CW-1:0]    count;
  logic             carry;
  logic             carry_init;
  logic             c_msb_in;
  logic             c_out_r;
  logic             overflow_r;
  logic             fa_sum;
  logic             fa_cout;
  logic             accept;
  logic             last_bit;

`ifdef SERIAL_ADD_SUB_EN
  // Subtract is A + ~B + 1: invert B on load and seed the carry with 1.
  assign b_load     = bus.op_sub ? ~bus.b_in : bus.b_in;
  assign carry_init = bus.op_sub;
`else
  assign b_load     = bus.b_in;
  assign carry_init = 1'b0;
`endif

  assign accept   = bus.start && ((state == IDLE) || (state == DONE));
  assign last_bit = (count == LAST_BIT);

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      RUN:     bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // Sum bits enter at the MSB so the result is right-aligned after WIDTH shifts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_sh       <= '0;
      b_sh       <= '0;
      result_r   <= '0;
      count      <= '0;
      carry      <= 1'b0;
      c_msb_in   <= 1'b0;
      c_out_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else if (accept) begin
      a_sh       <= bus.a_in;
      b_sh       <= b_load;
      result_r   <= '0;
      count      <= '0;
      carry      <= carry_init;
      c_msb_in   <= 1'b0;
      c_out_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else if (state == RUN) begin
      result_r <= {fa_sum, result_r[WIDTH-1:1]};
      a_sh     <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh     <= {1'b0, b_sh[WIDTH-1:1]};
      carry    <= fa_cout;
      count    <= count + 1'b1;
      if (count == MSB_M1) c_msb_in <= fa_cout;
      if (last_bit) begin
        c_out_r    <= fa_cout;
        overflow_r <= fa_cout ^ c_msb_in;
      end
    end
  end

  assign bus.result   = result_r;
  assign bus.c_out    = c_out_r;
  assign bus.overflow = overflow_r;
  assign bus.zero     = (result_r == '0);
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Table-driven, scoreboarded bench for serial_add_sequencer (WIDTH = 32).
// Honours SERIAL_ADD_SUB_EN the same way the design does.
module tb_serial_add_sequencer;
  localparam int WIDTH = 32;

  logic clock;
  logic reset;

  serial_add_sequencer_if #(.WIDTH(WIDTH)) bus ();

  serial_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] expResult;
    logic        expCout;
    logic        expOvf;
    logic        expZero;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] result;
    logic        cout;
    logic        ovf;
    logic        zero;
    string       name;
  } exp_t;

  exp_t scoreboard[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Independent reference: 33-bit behavioural sum with the same add-only fallback.
  function automatic vec_t makeVec(input logic [31:0] a, input logic [31:0] b, input logic sub, input string name);
    vec_t        v;
    logic [32:0] s;
    logic [31:0] bb;
    logic        subEff;
`ifdef SERIAL_ADD_SUB_EN
    subEff = sub;
`else
    subEff = 1'b0;
`endif
    bb = subEff ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {32'd0, subEff};
    v.a         = a;
    v.b         = b;
    v.sub       = sub;
    v.expResult = s[31:0];
    v.expCout   = s[32];
    v.expOvf    = (a[31] == bb[31]) && (s[31] != a[31]);
    v.expZero   = (s[31:0] == 32'd0);
    v.name      = name;
    return v;
  endfunction

  task automatic pushExpected(input vec_t v);
    exp_t e;
    e.result = v.expResult;
    e.cout   = v.expCout;
    e.ovf    = v.expOvf;
    e.zero   = v.expZero;
    e.name   = v.name;
    scoreboard.push_back(e);
  endtask

  // Pulses start for one cycle, then scrambles the operand inputs.
  task automatic applyStimulus(input vec_t v);
    @(negedge clock);
    bus.start  = 1'b1;
    bus.a_in   = v.a;
    bus.b_in   = v.b;
    bus.op_sub = v.sub;
    pushExpected(v);
    @(negedge clock);
    bus.start  = 1'b0;
    bus.a_in   = ~v.a;
    bus.b_in   = $urandom;
    bus.op_sub = ~v.sub;
  endtask

  task automatic waitDone(output int busyCount, output bit seen);
    busyCount = 0;
    seen      = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busyCount++;
      @(negedge clock);
    end
  endtask

  task automatic compareResult();
    exp_t e;
    if (scoreboard.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = scoreboard.pop_front();
      check({e.name, "_result"},   {32'd0, bus.result}, {32'd0, e.result});
      check({e.name, "_c_out"},    {63'd0, bus.c_out},    {63'd0, e.cout});
      check({e.name, "_overflow"}, {63'd0, bus.overflow}, {63'd0, e.ovf});
      check({e.name, "_zero"},     {63'd0, bus.zero},     {63'd0, e.zero});
      check({e.name, "_busy_at_done"}, {63'd0, bus.busy}, 64'd0);
    end
  endtask

  task automatic checkOutput(input int expBusy);
    int          busyCount;
    bit          seen;
    logic [31:0] held;
    waitDone(busyCount, seen);
    check("done_seen", {63'd0, seen}, 64'd1);
    if (seen) begin
      check("busy_cycles", 64'(busyCount), 64'(expBusy));
      held = bus.result;
      compareResult();
      @(negedge clock);
      check("done_one_cycle", {63'd0, bus.done}, 64'd0);
      check("idle_after_done", {63'd0, bus.busy}, 64'd0);
      check("result_held", {32'd0, bus.result}, {32'd0, held});
    end else if (scoreboard.size() > 0) begin
      void'(scoreboard.pop_front());
    end
  endtask

  initial begin
    vec_t v1;
    vec_t v2;
    int   busyCount;
    bit   seen;
    bit   doneSeen;

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op_sub = 1'b0;
    bus.a_in   = '0;
    bus.b_in   = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    check("reset_busy",     {63'd0, bus.busy},     64'd0);
    check("reset_done",     {63'd0, bus.done},     64'd0);
    check("reset_result",   {32'd0, bus.result},   64'd0);
    check("reset_zero",     {63'd0, bus.zero},     64'd1);
    check("reset_c_out",    {63'd0, bus.c_out},    64'd0);
    check("reset_overflow", {63'd0, bus.overflow}, 64'd0);

    vecs.push_back('{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0, "add_5_3"});
    vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "add_pos_ovf"});
    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "add_wrap"});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, "add_zeros"});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, "add_neg_ovf"});
    vecs.push_back('{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b0, "add_mixed"});
`ifdef SERIAL_ADD_SUB_EN
    vecs.push_back('{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "sub_5_5"});
    vecs.push_back('{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "sub_0_1"});
    vecs.push_back('{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, "sub_min_1"});
`else
    vecs.push_back('{32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, "sub_ignored"});
`endif
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(makeVec($urandom, $urandom, 1'($urandom_range(0, 1)), "random"));
    end

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput(WIDTH);
    end

    // A second start at RUN cycle 10 must be dropped without disturbing the first.
    v1 = makeVec(32'h1111_1111, 32'h2222_2222, 1'b0, "start_ignored");
    applyStimulus(v1);
    repeat (9) @(negedge clock);
    bus.start = 1'b1;
    bus.a_in  = 32'hFFFF_FFFF;
    bus.b_in  = 32'hFFFF_FFFF;
    @(negedge clock);
    bus.start = 1'b0;
    checkOutput(WIDTH - 10);

    // Start held in the DONE cycle chains straight into the next operation.
    v1 = makeVec(32'h0000_FFFF, 32'h0000_0001, 1'b0, "chain_first");
    v2 = makeVec(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, "chain_second");
    applyStimulus(v1);
    waitDone(busyCount, seen);
    check("chain_done_seen", {63'd0, seen}, 64'd1);
    bus.start  = 1'b1;
    bus.a_in   = v2.a;
    bus.b_in   = v2.b;
    bus.op_sub = v2.sub;
    pushExpected(v2);
    compareResult();
    @(negedge clock);
    bus.start = 1'b0;
    check("chain_busy_next", {63'd0, bus.busy}, 64'd1);
    check("chain_done_low",  {63'd0, bus.done}, 64'd0);
    checkOutput(WIDTH);

    // Reset pulse mid-RUN discards the operation.
    v1 = makeVec(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, "reset_mid_run");
    applyStimulus(v1);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst_busy",     {63'd0, bus.busy},     64'd0);
    check("midrst_done",     {63'd0, bus.done},     64'd0);
    check("midrst_result",   {32'd0, bus.result},   64'd0);
    check("midrst_zero",     {63'd0, bus.zero},     64'd1);
    check("midrst_c_out",    {63'd0, bus.c_out},    64'd0);
    check("midrst_overflow", {63'd0, bus.overflow}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    void'(scoreboard.pop_back());
    doneSeen = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (bus.done) doneSeen = 1'b1;
    end
    check("midrst_no_done", {63'd0, doneSeen}, 64'd0);
    check("midrst_idle",    {63'd0, bus.busy}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
